// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Per-channel switch conditioner. Two-flop synchroniser, a
//               stability counter that accepts a new level only after
//               STABLE_CYCLES consecutive mismatched samples, a registered
//               debounced level and one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int               CNT_W     = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Two-flop synchroniser; only r_sync2 is seen by the debounce logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Each channel debounces independently of the others.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [CNT_W-1:0] r_cnt;
        logic             r_out;
        logic             r_rise;
        logic             r_fall;
        logic             w_mismatch;
        logic             w_accept;

        // A single matching sample clears the run, so any bounce restarts it.
        assign w_mismatch = (r_sync2[i] != r_out);
        assign w_accept   = w_mismatch && (r_cnt == C_CNT_MAX);

        // Stability counter, debounced level and edge pulses for this channel.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt  <= '0;
                r_out  <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (!w_mismatch) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    // Counter saturates at C_CNT_MAX and is cleared here, never wraps.
                    r_cnt  <= '0;
                    r_out  <= r_sync2[i];
                    r_rise <= r_sync2[i];
                    r_fall <= ~r_sync2[i];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign sw_out[i]  = r_out;
        assign sw_rise[i] = r_rise;
        assign sw_fall[i] = r_fall;
    end

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debounce
// Description : Self-checking bench for sw_debounce (WIDTH=4, STABLE_CYCLES=8).
//               Directed scenarios plus randomized bouncing inputs compared
//               against a sliding-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

    localparam int W = 4;
    localparam int S = 8;
    localparam int HMAX = 8192;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;

    int checks = 0;
    int errors = 0;

    sw_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk    (clk),
        .reset  (reset),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall)
    );

    always #5 clk = ~clk;

    // Reference model: history of what reaches the debouncer each edge.
    // A channel flips at edge e when the S most recent samples (edges
    // e-S+1..e) all differ from its level and none precede its last
    // flip or reset.
    int           e = -1;
    bit           rst_h [HMAX];
    logic [W-1:0] s1_h  [HMAX];
    logic [W-1:0] d_h   [HMAX];
    int           start [W];
    logic [W-1:0] m_out  = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;

    task automatic model_edge(input bit r, input logic [W-1:0] x);
        logic [W-1:0] d;
        bit ok;
        e++;
        rst_h[e] = r;
        s1_h[e]  = r ? '0 : x;
        d = '0;
        if (e >= 2) begin
            if (!rst_h[e-1]) d = s1_h[e-2];
        end
        d_h[e] = d;
        m_rise = '0;
        m_fall = '0;
        if (r) begin
            m_out = '0;
            for (int i = 0; i < W; i++) start[i] = e + 1;
        end else begin
            for (int i = 0; i < W; i++) begin
                ok = (e - S + 1 >= start[i]);
                for (int k = e - S + 1; k <= e; k++)
                    if (ok && d_h[k][i] == m_out[i]) ok = 0;
                if (ok) begin
                    m_out[i]  = ~m_out[i];
                    m_rise[i] = m_out[i];
                    m_fall[i] = ~m_out[i];
                    start[i]  = e + 1;
                end
            end
        end
    endtask

    // One clock edge: update the model with the inputs seen at the edge,
    // then leave time for DUT outputs to settle before any sampling.
    task automatic tick();
        @(posedge clk);
        model_edge(reset, sw_in);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw_in = 4'b1111;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if ({sw_out, sw_rise, sw_fall} !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: out=%b rise=%b fall=%b, required all 0",
                         n, sw_out, sw_rise, sw_fall);
            end
        end
        reset = 1'b0;
        sw_in = 4'b0000;
        for (int n = 0; n < 12; n++) tick();
        checks++;
        if ({sw_out, sw_rise, sw_fall} !== 12'h000) begin
            errors++;
            $display("FAIL reset_release: out=%b rise=%b fall=%b, required all 0",
                     sw_out, sw_rise, sw_fall);
        end
    endtask

    task automatic test_latency();
        sw_in = 4'b0001;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if (sw_out !== ((n >= 9) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL latency_out edge %0d: got %b, required %b",
                         n, sw_out, (n >= 9) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if (sw_rise !== ((n == 9) ? 4'b0001 : 4'b0000) || sw_fall !== 4'b0000) begin
                errors++;
                $display("FAIL latency_pulse edge %0d: rise=%b fall=%b, required rise=%b fall=0000",
                         n, sw_rise, sw_fall, (n == 9) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_glitch();
        int rises;
        int falls;
        sw_in = 4'b0011;
        for (int n = 0; n < 20; n++) begin
            if (n == 7) sw_in = 4'b0001;
            tick();
            checks++;
            if (sw_out !== 4'b0001 || sw_rise !== 4'b0000) begin
                errors++;
                $display("FAIL glitch7 edge %0d: out=%b rise=%b, required out=0001 rise=0000",
                         n, sw_out, sw_rise);
            end
        end
        rises = 0;
        falls = 0;
        sw_in = 4'b0011;
        for (int n = 0; n < 25; n++) begin
            if (n == 8) sw_in = 4'b0001;
            tick();
            if (sw_rise[1]) rises++;
            if (sw_fall[1]) falls++;
            checks++;
            if (sw_out[1] !== ((n >= 9 && n < 17) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL glitch8_out edge %0d: out[1]=%b, required %b",
                         n, sw_out[1], (n >= 9 && n < 17) ? 1'b1 : 1'b0);
            end
        end
        checks++;
        if (rises != 1 || falls != 1) begin
            errors++;
            $display("FAIL glitch8_pulses: rises=%0d falls=%0d, required 1 and 1", rises, falls);
        end
    endtask

    task automatic test_fall();
        sw_in = 4'b0000;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if (sw_out !== ((n >= 9) ? 4'b0000 : 4'b0001)) begin
                errors++;
                $display("FAIL fall_out edge %0d: got %b, required %b",
                         n, sw_out, (n >= 9) ? 4'b0000 : 4'b0001);
            end
            checks++;
            if (sw_fall !== ((n == 9) ? 4'b0001 : 4'b0000) || sw_rise !== 4'b0000) begin
                errors++;
                $display("FAIL fall_pulse edge %0d: fall=%b rise=%b, required fall=%b rise=0000",
                         n, sw_fall, sw_rise, (n == 9) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_simultaneous();
        sw_in = 4'b1111;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if (sw_out !== ((n >= 9) ? 4'b1111 : 4'b0000) ||
                sw_rise !== ((n == 9) ? 4'b1111 : 4'b0000)) begin
                errors++;
                $display("FAIL simultaneous edge %0d: out=%b rise=%b, required out=%b rise=%b",
                         n, sw_out, sw_rise, (n >= 9) ? 4'b1111 : 4'b0000,
                         (n == 9) ? 4'b1111 : 4'b0000);
            end
        end
        sw_in = 4'b0000;
        for (int n = 0; n < 12; n++) tick();
        checks++;
        if (sw_out !== 4'b0000) begin
            errors++;
            $display("FAIL simultaneous_clear: out=%b, required 0000", sw_out);
        end
    endtask

    task automatic test_reset_mid();
        sw_in = 4'b0100;
        for (int n = 0; n < 19; n++) begin
            reset = (n == 5);
            tick();
            checks++;
            if (sw_out !== ((n >= 15) ? 4'b0100 : 4'b0000) ||
                sw_rise !== ((n == 15) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL reset_mid edge %0d: out=%b rise=%b, required out=%b rise=%b",
                         n, sw_out, sw_rise, (n >= 15) ? 4'b0100 : 4'b0000,
                         (n == 15) ? 4'b0100 : 4'b0000);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) sw_in = sw_in ^ W'($urandom_range(1, 15));
            reset = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if (sw_out !== m_out || sw_rise !== m_rise || sw_fall !== m_fall) begin
                errors++;
                $display("FAIL random edge %0d: out=%b rise=%b fall=%b, required out=%b rise=%b fall=%b",
                         n, sw_out, sw_rise, sw_fall, m_out, m_rise, m_fall);
            end
            checks++;
            if ((sw_rise & sw_fall) !== 4'b0000) begin
                errors++;
                $display("FAIL random_both_pulses edge %0d: rise=%b fall=%b, required no overlap",
                         n, sw_rise, sw_fall);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < W; i++) start[i] = 0;
        test_reset();
        test_latency();
        test_glitch();
        test_fall();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
